// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one fixed-latency 32-bit memory between instruction fetch and load/store,
// one transaction at a time, LS priority with a starvation guard for IF.
module mem_arbiter #(
  parameter int ADDR_W     = 13,
  parameter int LATENCY    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  input  logic [3:0]        ls_be,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [31:0]       ls_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [31:0]       mem_rdata,
  output logic              busy,
  output logic              owner
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t            state_q, state_d;
  logic [3:0]        starve_q, starve_d;
  logic [2:0]        wait_q, wait_d;
  logic              owner_q, owner_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d, if_rdata_q, if_rdata_d, ls_rdata_q, ls_rdata_d;
  logic [3:0]        be_q, be_d;
  logic              opp, if_wins, grant, capture;

  always_comb begin
    opp = rst && (state_q == IDLE || state_q == DONE);
    if_wins = if_req && (!ls_req || starve_q == 4'(STARVE_MAX));
    if_gnt = opp && if_wins;
    ls_gnt = opp && ls_req && !if_wins;
    grant = if_gnt || ls_gnt;
    capture = state_q == WAIT && wait_q == 3'd1;
    // LS can only beat a waiting IF below STARVE_MAX, so the increment saturates by construction
    starve_d = !opp ? starve_q : (if_req && ls_gnt) ? starve_q + 4'd1 : 4'd0;
    state_d = state_q == ISSUE ? WAIT :
              state_q == WAIT  ? (wait_q == 3'd1 ? DONE : WAIT) :
              grant            ? ISSUE : IDLE;
    wait_d = state_q == ISSUE ? 3'(LATENCY) : state_q == WAIT ? wait_q - 3'd1 : wait_q;
    owner_d = grant ? ls_gnt : owner_q;
    we_d = grant ? ls_gnt && ls_we : we_q;
    addr_d = if_gnt ? if_addr : ls_gnt ? ls_addr : addr_q;
    wdata_d = ls_gnt ? ls_wdata : wdata_q;
    be_d = if_gnt ? 4'hF : ls_gnt ? ls_be : be_q;
    if_rdata_d = capture && !owner_q ? mem_rdata : if_rdata_q;
    ls_rdata_d = capture && owner_q && !we_q ? mem_rdata : ls_rdata_q;
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q    <= IDLE;
      starve_q   <= '0;
      wait_q     <= '0;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      wait_q     <= wait_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      if_rdata_q <= if_rdata_d;
      ls_rdata_q <= ls_rdata_d;
    end

  assign mem_req   = state_q == ISSUE;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;
  assign busy      = state_q != IDLE;
  assign owner     = owner_q;
  assign if_rvalid = state_q == DONE && !owner_q;
  assign ls_rvalid = state_q == DONE && owner_q;
  assign if_rdata  = if_rdata_q;
  assign ls_rdata  = ls_rdata_q;
endmodule
